alu_result_stage: RTL and testbench

//  Execute-stage back end directly downstream of the 64-bit ALU. Registers the ALU result and flags

---
 rtl/alu_stage_pkg.sv | 39 +++
 rtl/cond_check.sv | 33 +++
 rtl/alu_result_stage.sv | 123 ++++++++++++
 tb/tb_alu_result_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_stage_pkg.sv
// Shared types for the ALU result stage: NZCV flag layout, B.cond condition
// codes, buffered entry format and the fixed buffer depth.
package alu_stage_pkg;

  localparam int DEPTH    = 2;
  localparam int RESULT_W = 64;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_HS = 4'h2,
    COND_LO = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  typedef struct packed {
    logic [RESULT_W-1:0] result;
    logic                take_branch;
  } entry_t;

endpackage

// File: rtl/cond_check.sv
// Combinational LEGv8 B.cond evaluator: decides whether a condition code holds
// for a given NZCV flag set. AL and NV both evaluate as always true.
module cond_check
  import alu_stage_pkg::*;
(
  input  flags_t flags_i,
  input  cond_e  cond_i,
  output logic   cond_true_o
);

  // Decode the condition code against the supplied flags
  always_comb begin
    cond_true_o = 1'b1;
    case (cond_i)
      COND_EQ: cond_true_o = flags_i.z;
      COND_NE: cond_true_o = ~flags_i.z;
      COND_HS: cond_true_o = flags_i.c;
      COND_LO: cond_true_o = ~flags_i.c;
      COND_MI: cond_true_o = flags_i.n;
      COND_PL: cond_true_o = ~flags_i.n;
      COND_VS: cond_true_o = flags_i.v;
      COND_VC: cond_true_o = ~flags_i.v;
      COND_HI: cond_true_o = flags_i.c & ~flags_i.z;
      COND_LS: cond_true_o = ~flags_i.c | flags_i.z;
      COND_GE: cond_true_o = (flags_i.n == flags_i.v);
      COND_LT: cond_true_o = (flags_i.n != flags_i.v);
      COND_GT: cond_true_o = ~flags_i.z & (flags_i.n == flags_i.v);
      COND_LE: cond_true_o = flags_i.z | (flags_i.n != flags_i.v);
      default: cond_true_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_result_stage.sv
// Execute-stage back end behind the ALU: a 2-entry valid/ready buffer carrying
// result + resolved B.cond decision to MEM, plus the architectural NZCV register.
// The branch condition is judged against the flags held before this cycle's
// update, so a flag-setting B.cond sees the older flags.
// Optional feature macro: ALU_STICKY_OVF_EN adds clr_sticky / sticky_ovf, a
// sticky record of any flag-setting overflow.
module alu_result_stage
  import alu_stage_pkg::*;
#(
  parameter int WIDTH = RESULT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_negative,
  input  logic             in_zero,
  input  logic             in_overflow,
  input  logic             in_carry_out,
  input  logic             in_set_flags,
  input  logic             in_is_bcond,
  input  logic [3:0]       in_cond,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_take_branch,
`ifdef ALU_STICKY_OVF_EN
  input  logic             clr_sticky,
  output logic             sticky_ovf,
`endif
  output logic [3:0]       flags_q
);

  entry_t     mem_q [DEPTH];
  entry_t     head_entry;
  entry_t     wr_entry;
  logic       head_q, head_d;
  logic       tail_q, tail_d;
  logic [1:0] count_q, count_d;
  logic [3:0] flags_d;
  logic       accept, pop;
  logic       cond_true;
  flags_t     cur_flags;

  assign cur_flags = flags_t'(flags_q);

  cond_check u_cond_check (
    .flags_i     (cur_flags),
    .cond_i      (cond_e'(in_cond)),
    .cond_true_o (cond_true)
  );

  assign in_ready  = (count_q != 2'(DEPTH));
  assign out_valid = (count_q != 2'd0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign wr_entry.result      = in_result;
  assign wr_entry.take_branch = in_is_bcond & cond_true;

  // Empty buffer presents zeros so stale storage never leaks to MEM
  assign head_entry      = mem_q[head_q];
  assign out_result      = out_valid ? head_entry.result : '0;
  assign out_take_branch = out_valid & head_entry.take_branch;

  // Pointer, occupancy and flag next-state
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    flags_d = flags_q;
    if (pop)    head_d = ~head_q;
    if (accept) tail_d = ~tail_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (accept && in_set_flags)
      flags_d = {in_negative, in_zero, in_carry_out, in_overflow};
  end

  // Control state; reset empties the buffer so no entry survives it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
      flags_q <= 4'b0000;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      flags_q <= flags_d;
    end
  end

  // Entry storage; contents only matter while counted as occupied
  always_ff @(posedge clk) begin
    if (accept) mem_q[tail_q] <= wr_entry;
  end

`ifdef ALU_STICKY_OVF_EN
  logic sticky_q, sticky_d;

  assign sticky_ovf = sticky_q;

  // A new overflow wins over a simultaneous clear
  always_comb begin
    sticky_d = sticky_q;
    if (accept && in_set_flags && in_overflow) sticky_d = 1'b1;
    else if (clr_sticky)                       sticky_d = 1'b0;
  end

  // Sticky overflow register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sticky_q <= 1'b0;
    else          sticky_q <= sticky_d;
  end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [63:0] in_result;
  logic        in_negative, in_zero, in_overflow, in_carry_out;
  logic        in_set_flags, in_is_bcond;
  logic [3:0]  in_cond;
  logic        out_valid, out_ready;
  logic [63:0] out_result;
  logic        out_take_branch;
  logic [3:0]  flags_q;
`ifdef ALU_STICKY_OVF_EN
  logic        clr_sticky, sticky_ovf;
`endif

  always #5 clk = ~clk;

  alu_result_stage dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_result       (in_result),
    .in_negative     (in_negative),
    .in_zero         (in_zero),
    .in_overflow     (in_overflow),
    .in_carry_out    (in_carry_out),
    .in_set_flags    (in_set_flags),
    .in_is_bcond     (in_is_bcond),
    .in_cond         (in_cond),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_result      (out_result),
    .out_take_branch (out_take_branch),
`ifdef ALU_STICKY_OVF_EN
    .clr_sticky      (clr_sticky),
    .sticky_ovf      (sticky_ovf),
`endif
    .flags_q         (flags_q)
  );

  typedef struct {
    logic [63:0] res;
    bit          take;
  } exp_t;

  exp_t   mq[$];
  bit [3:0] mflags;   // {N,Z,C,V}
  bit     msticky;
  int     n_vec;
  int     n_miscmp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_holds(input bit [3:0] code, input bit [3:0] f);
    bit n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (code)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic compare_all();
    chk("in_ready", in_ready, (mq.size() < 2));
    chk("out_valid", out_valid, (mq.size() != 0));
    if (mq.size() != 0) begin
      chk("out_result", out_result, mq[0].res);
      chk("out_take", out_take_branch, mq[0].take);
    end
    chk("flags", flags_q, mflags);
`ifdef ALU_STICKY_OVF_EN
    chk("sticky", sticky_ovf, msticky);
`endif
  endtask

  // Advance model for the coming rising edge, then compare at the next falling edge
  task automatic tick();
    bit   acc, pp;
    exp_t e;
    acc = in_valid && (mq.size() < 2);
    pp  = (mq.size() > 0) && out_ready;
    if (pp) void'(mq.pop_front());
    if (acc) begin
      e.res  = in_result;
      e.take = in_is_bcond && cond_holds(in_cond, mflags);
      mq.push_back(e);
    end
`ifdef ALU_STICKY_OVF_EN
    if (acc && in_set_flags && in_overflow) msticky = 1'b1;
    else if (clr_sticky)                    msticky = 1'b0;
`endif
    if (acc && in_set_flags) mflags = {in_negative, in_zero, in_carry_out, in_overflow};
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    in_valid = 0; in_result = '0; in_negative = 0; in_zero = 0; in_overflow = 0;
    in_carry_out = 0; in_set_flags = 0; in_is_bcond = 0; in_cond = 4'h0;
  endtask

  task automatic push(input logic [63:0] r, input bit [3:0] nzcv, input bit setf,
                      input bit bc, input bit [3:0] cc);
    in_valid = 1; in_result = r;
    in_negative = nzcv[3]; in_zero = nzcv[2]; in_carry_out = nzcv[1]; in_overflow = nzcv[0];
    in_set_flags = setf; in_is_bcond = bc; in_cond = cc;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_flags"}, flags_q, 0);
    chk({tag, "_out_result"}, out_result, 0);
    chk({tag, "_out_take"}, out_take_branch, 0);
`ifdef ALU_STICKY_OVF_EN
    chk({tag, "_sticky"}, sticky_ovf, 0);
`endif
  endtask

  initial begin
    n_vec = 0; n_miscmp = 0; mflags = 0; msticky = 0;
    idle();
    out_ready = 0;
`ifdef ALU_STICKY_OVF_EN
    clr_sticky = 0;
`endif
    // Reset held with in_valid asserted
    reset_n = 0;
    push(64'h1234, 4'hF, 1, 1, 4'hE);
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    reset_n = 1;
    idle();
    tick();

    // Pass-through
    out_ready = 1;
    push(64'd255, 4'h0, 0, 0, 4'h0);
    tick();
    chk("pt_result", out_result, 64'd255);
    idle();
    tick();
    chk("pt_one_beat", out_valid, 0);

    // Backpressure
    out_ready = 0;
    push(64'd11, 4'h0, 0, 0, 4'h0); tick();
    push(64'd22, 4'h0, 0, 0, 4'h0); tick();
    chk("bp_full", in_ready, 0);
    push(64'd33, 4'h0, 0, 0, 4'h0); tick();
    chk("bp_head_stable", out_result, 64'd11);
    idle(); out_ready = 1;
    tick();
    chk("bp_drain2", out_result, 64'd22);
    tick();
    chk("bp_empty", out_valid, 0);

    // Flags and conditions
    push(64'd0, 4'b0110, 1, 0, 4'h0); tick();           // SUBS result 0: N0 Z1 C1 V0
    push(64'd1, 4'h0, 0, 1, 4'h0); tick();              // B.EQ
    chk("beq_taken", out_take_branch, 1);
    push(64'd2, 4'h0, 0, 1, 4'h1); tick();              // B.NE
    chk("bne_not_taken", out_take_branch, 0);
    push(64'd3, 4'b1001, 1, 0, 4'h0); tick();           // ADDS N1 V1
    push(64'd4, 4'h0, 0, 1, 4'hA); tick();              // B.GE
    chk("bge_taken", out_take_branch, 1);
    push(64'd5, 4'h0, 0, 1, 4'hB); tick();              // B.LT
    chk("blt_not_taken", out_take_branch, 0);

    // Condition sees flags from before this accept
    push(64'd6, 4'b0100, 1, 1, 4'h0); tick();
    chk("preupd_take", out_take_branch, 0);
    chk("preupd_z", flags_q[2], 1);
    idle(); tick();

`ifdef ALU_STICKY_OVF_EN
    push(64'd7, 4'b0001, 1, 0, 4'h0); tick();
    chk("sticky_set", sticky_ovf, 1);
    push(64'd8, 4'b0000, 1, 0, 4'h0); tick();
    chk("sticky_hold", sticky_ovf, 1);
    idle(); clr_sticky = 1; tick();
    chk("sticky_clr", sticky_ovf, 0);
    clr_sticky = 0;
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      push({$urandom, $urandom}, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
`ifdef ALU_STICKY_OVF_EN
      clr_sticky = ($urandom_range(0, 7) == 0);
`endif
      tick();
    end
`ifdef ALU_STICKY_OVF_EN
    clr_sticky = 0;
`endif

    // Reset in the middle of a backed-up transfer
    out_ready = 0;
    push(64'hAA, 4'b1111, 1, 0, 4'h0); tick();
    push(64'hBB, 4'b1111, 1, 0, 4'h0); tick();
    reset_n = 0;
    #1;
    check_reset_state("midrst");
    mq.delete(); mflags = 0; msticky = 0;
    @(negedge clk);
    reset_n = 1;
    idle(); out_ready = 1;
    tick();
    chk("midrst_empty", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
